servive_uart_tx: RTL and testbench

- Wishbone-attached hardware UART transmitter for the servive board top; replaces the bit-banged GPIO drive of uart_txd.
- Parametrised over data bits, stop bits, FIFO depth and baud divisor; divisor is also runtime-programmable.
- Buffers bytes in a FIFO so firmware can push a burst without cycle-counting; exposes status for polling.

---
 rtl/servive_uart_tx_if.sv | 19 +
 rtl/servive_uart_tx.sv | 210 +++++++++++++++++++++
 tb/tb_servive_uart_tx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/servive_uart_tx_if.sv
// Wishbone slave bundle for servive_uart_tx: register select, write data, strobes and response.
interface servive_uart_tx_if;
    logic        i_wb_adr;
    logic [31:0] i_wb_dat;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
        input  o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
        output o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/servive_uart_tx.sv
// Wishbone UART transmitter with TX FIFO, programmable divisor and status register.
// Optional parity bit enabled by defining SERVIVE_UART_TX_PARITY_EN.
module servive_uart_tx #(
    parameter logic [15:0] DIV_DEFAULT = 16'd868,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    servive_uart_tx_if.slave wb,
    output logic             o_tx,
    output logic             o_busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(DATA_BITS);

`ifdef SERVIVE_UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic                 r_ack;
    logic                 r_ovf;
    logic [15:0]          r_div;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]        r_count;
    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [IW-1:0]        r_bit_idx;
    logic [16:0]          r_cnt;
    logic [15:0]          r_bit_len;
    logic                 r_tx, r_busy;
`ifdef SERVIVE_UART_TX_PARITY_EN
    logic                 r_odd, r_par;
`endif

    logic                 w_acc, w_wr, w_rd, w_push_req, w_push, w_pop, w_ovf_set;
    logic                 w_empty, w_full;
    logic [DATA_BITS-1:0] w_head;
    logic [16:0]          w_bit_last, w_stop_last;
    logic [31:0]          w_rdt;
    logic                 w_unused_dat;

    // Accesses commit in the ack cycle, while the master still holds cyc.
    assign w_acc       = wb.i_wb_cyc & r_ack;
    assign w_wr        = w_acc & wb.i_wb_we;
    assign w_rd        = w_acc & !wb.i_wb_we;
    assign w_push_req  = w_wr & !wb.i_wb_adr;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_head      = r_mem[r_rd_ptr];
    assign w_pop       = !w_empty && ((r_state == S_IDLE) || (r_state == S_STOP && r_cnt == '0));
    assign w_push      = w_push_req & (!w_full | w_pop);
    assign w_ovf_set   = w_push_req & w_full & !w_pop;
    assign w_bit_last  = {1'b0, r_bit_len} - 17'd1;
    assign w_stop_last = (STOP_BITS == 2) ? {r_bit_len, 1'b0} - 17'd1 : w_bit_last;
    assign w_unused_dat = ^wb.i_wb_dat;

    always_comb begin
        w_rdt = '0;
        if (r_ack && !wb.i_wb_we) begin
            if (wb.i_wb_adr) begin
                w_rdt[15:0] = r_div;
`ifdef SERVIVE_UART_TX_PARITY_EN
                w_rdt[16]   = r_odd;
`endif
            end else begin
                w_rdt[0]    = w_empty;
                w_rdt[1]    = w_full;
                w_rdt[2]    = r_ovf;
                w_rdt[3]    = r_busy;
                w_rdt[15:8] = 8'(r_count);
            end
        end
    end

    assign wb.o_wb_rdt = w_rdt;
    assign wb.o_wb_ack = r_ack;
    assign o_tx        = r_tx;
    assign o_busy      = r_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack <= 1'b0;
            r_ovf <= 1'b0;
            r_div <= DIV_DEFAULT;
`ifdef SERVIVE_UART_TX_PARITY_EN
            r_odd <= 1'b0;
`endif
        end else begin
            r_ack <= wb.i_wb_cyc & !r_ack;
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_rd && !wb.i_wb_adr)
                r_ovf <= 1'b0;
            if (w_wr && wb.i_wb_adr) begin
                r_div <= (wb.i_wb_dat[15:0] == 16'd0) ? 16'd1 : wb.i_wb_dat[15:0];
`ifdef SERVIVE_UART_TX_PARITY_EN
                r_odd <= wb.i_wb_dat[16];
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= wb.i_wb_dat[DATA_BITS-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_cnt     <= '0;
            r_bit_len <= '0;
            r_busy    <= 1'b0;
`ifdef SERVIVE_UART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_busy <= !w_empty || (r_state != S_IDLE);
            // Pop from IDLE or at the end of STOP; the latter chains frames with no idle gap.
            if (w_pop) begin
                r_state   <= S_START;
                r_tx      <= 1'b0;
                r_shift   <= w_head;
                r_bit_len <= r_div;
                r_cnt     <= {1'b0, r_div} - 17'd1;
                r_bit_idx <= '0;
`ifdef SERVIVE_UART_TX_PARITY_EN
                r_par     <= (^w_head) ^ r_odd;
`endif
            end else begin
                case (r_state)
                    S_IDLE: r_tx <= 1'b1;
                    S_START: begin
                        if (r_cnt == '0) begin
                            r_state <= S_DATA;
                            r_tx    <= r_shift[0];
                            r_cnt   <= w_bit_last;
                        end else begin
                            r_cnt <= r_cnt - 17'd1;
                        end
                    end
                    S_DATA: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 17'd1;
                        end else if (r_bit_idx == IW'(DATA_BITS - 1)) begin
                            r_bit_idx <= '0;
`ifdef SERVIVE_UART_TX_PARITY_EN
                            r_state   <= S_PARITY;
                            r_tx      <= r_par;
                            r_cnt     <= w_bit_last;
`else
                            r_state   <= S_STOP;
                            r_tx      <= 1'b1;
                            r_cnt     <= w_stop_last;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + IW'(1);
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_cnt     <= w_bit_last;
                        end
                    end
`ifdef SERVIVE_UART_TX_PARITY_EN
                    S_PARITY: begin
                        if (r_cnt == '0) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                            r_cnt   <= w_stop_last;
                        end else begin
                            r_cnt <= r_cnt - 17'd1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (r_cnt == '0)
                            r_state <= S_IDLE;
                        else
                            r_cnt <= r_cnt - 17'd1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_servive_uart_tx.sv
// Self-checking bench for servive_uart_tx: bus/status checks plus cycle-exact o_tx waveform model.
module tb_servive_uart_tx;
    localparam int unsigned DB = 8;
    localparam int unsigned SB = 1;
    localparam int unsigned FD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx, busy;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    bit exp_q[$];
    bit chk_on = 1'b0;

    servive_uart_tx_if bus ();

    servive_uart_tx #(
        .DIV_DEFAULT (16'd868),
        .FIFO_DEPTH  (FD),
        .DATA_BITS   (DB),
        .STOP_BITS   (SB)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .wb      (bus.slave),
        .o_tx    (tx),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected line level, one entry per clock, built from frame rules.
    always @(negedge clk) begin
        if (chk_on) begin
            if (exp_q.size() == 0) begin
                chk_on = 1'b0;
            end else begin
                bit e;
                e = exp_q.pop_front();
                check("tx_wave", {31'b0, tx}, {31'b0, e});
            end
        end
    end

    function automatic void add_level(input bit lvl, input int unsigned n);
        repeat (n) exp_q.push_back(lvl);
    endfunction

    function automatic void add_frame(input logic [7:0] b, input int unsigned div, input bit odd);
        bit p;
        p = odd;
        add_level(1'b0, div);
        for (int i = 0; i < DB; i++) begin
            add_level(b[i], div);
            p = p ^ b[i];
        end
`ifdef SERVIVE_UART_TX_PARITY_EN
        add_level(p, div);
`endif
        add_level(1'b1, SB * div);
    endfunction

    task automatic wb_xfer(input bit we, input bit adr, input logic [31:0] dat, output logic [31:0] rdt);
        int unsigned n;
        n = 0;
        @(posedge clk); #1;
        bus.i_wb_cyc = 1'b1;
        bus.i_wb_we  = we;
        bus.i_wb_adr = adr;
        bus.i_wb_dat = dat;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_wb_ack && n < 8);
        check("wb_ack", {31'b0, bus.o_wb_ack}, 32'd1);
        rdt = bus.o_wb_rdt;
        @(posedge clk); #1;
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_we  = 1'b0;
    endtask

    task automatic wb_write(input bit adr, input logic [31:0] dat);
        logic [31:0] d;
        wb_xfer(1'b1, adr, dat, d);
    endtask

    task automatic wb_read_check(input string tag, input bit adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(1'b0, adr, 32'h0, d);
        check(tag, d, exp);
    endtask

    task automatic wait_chk(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (chk_on && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wave_done", {31'b0, chk_on}, 32'd0);
    endtask

    // Call right after the data write returns: one idle sample precedes the start bit.
    task automatic start_wave();
        exp_q.push_front(1'b1);
        add_level(1'b1, 3);
        chk_on = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  bytes [10];
        logic [7:0]  b;
        int unsigned div;

        bus.i_wb_cyc = 1'b0;
        bus.i_wb_we  = 1'b0;
        bus.i_wb_adr = 1'b0;
        bus.i_wb_dat = '0;

        repeat (3) @(negedge clk);
        check("rst_tx",   {31'b0, tx},           32'd1);
        check("rst_ack",  {31'b0, bus.o_wb_ack}, 32'd0);
        check("rst_rdt",  bus.o_wb_rdt,          32'd0);
        check("rst_busy", {31'b0, busy},         32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        wb_read_check("status_reset", 1'b0, 32'h0000_0001);
        wb_read_check("div_reset",    1'b1, 32'd868);

        // 0x55 at div 4
        wb_write(1'b1, 32'd4);
        wb_write(1'b0, 32'h55);
        add_frame(8'h55, 4, 1'b0);
        start_wave();
        repeat (20) @(negedge clk);
        check("busy_mid", {31'b0, busy}, 32'd1);
        wait_chk(200);
        check("busy_after", {31'b0, busy}, 32'd0);
        wb_read_check("status_idle", 1'b0, 32'h0000_0001);

        // Randomized single frames
        for (int k = 0; k < 4; k++) begin
            div = $urandom_range(1, 6);
            b   = 8'($urandom);
            wb_write(1'b1, div);
            wb_write(1'b0, {24'b0, b});
            add_frame(b, div, 1'b0);
            start_wave();
            wait_chk(200);
        end

        // Divisor 0 stored as 1
        wb_write(1'b1, 32'd0);
        wb_read_check("div_zero", 1'b1, 32'd1);
        wb_write(1'b0, 32'hA3);
        add_frame(8'hA3, 1, 1'b0);
        start_wave();
        wait_chk(100);

        // Divisor change mid-frame only affects the next frame
        wb_write(1'b1, 32'd4);
        b = 8'($urandom);
        bytes[0] = 8'($urandom);
        wb_write(1'b0, {24'b0, bytes[0]});
        add_frame(bytes[0], 4, 1'b0);
        add_frame(b, 8, 1'b0);
        start_wave();
        wb_write(1'b1, 32'd8);
        wb_write(1'b0, {24'b0, b});
        wait_chk(400);

        // FIFO fill and overflow at div 100
        wb_write(1'b1, 32'd100);
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
        wb_write(1'b0, {24'b0, bytes[0]});
        for (int i = 0; i < 9; i++) add_frame(bytes[i], 100, 1'b0);
        start_wave();
        for (int i = 1; i < 10; i++) wb_write(1'b0, {24'b0, bytes[i]});
        wb_read_check("status_full_ovf", 1'b0, 32'h0000_080E);
        wb_read_check("status_ovf_clr",  1'b0, 32'h0000_080A);
        wait_chk(12000);
        wb_read_check("status_drained", 1'b0, 32'h0000_0001);

        // Parity (DIV bit 16 selects odd when the feature is built in)
        wb_write(1'b1, 32'h0001_0002);
`ifdef SERVIVE_UART_TX_PARITY_EN
        wb_read_check("div_par_odd", 1'b1, 32'h0001_0002);
        wb_write(1'b0, 32'h07);
        add_frame(8'h07, 2, 1'b1);
        start_wave();
        wait_chk(100);
        wb_write(1'b1, 32'h0000_0002);
        wb_write(1'b0, 32'h07);
        add_frame(8'h07, 2, 1'b0);
        start_wave();
        wait_chk(100);
`else
        wb_read_check("div_bit16_ignored", 1'b1, 32'h0000_0002);
        wb_write(1'b0, 32'h07);
        add_frame(8'h07, 2, 1'b0);
        start_wave();
        wait_chk(100);
`endif

        // Asynchronous reset during data bit 3 of 0xF0 (bit 3 is 0)
        wb_write(1'b1, 32'd4);
        wb_write(1'b0, 32'hF0);
        repeat (18) @(posedge clk);
        #1;
        check("tx_data_bit3", {31'b0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("tx_async_rst",   {31'b0, tx},   32'd1);
        check("busy_async_rst", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wb_read_check("status_after_rst", 1'b0, 32'h0000_0001);
        wb_read_check("div_after_rst",    1'b1, 32'd868);
        exp_q.delete();
        add_level(1'b1, 60);
        chk_on = 1'b1;
        wait_chk(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
